// File: rtl/control_sequencer_pkg.sv
// Opcode, ALU-select, state and instruction-class definitions shared by the control sequencer.
package control_sequencer_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  // One-hot instruction class produced by the opcode decoder.
  typedef struct packed {
    logic alu;
    logic ld;
    logic ldi;
    logic st;
    logic nop;
    logic halt;
    logic bad;
  } op_class_t;

endpackage

// File: rtl/control_sequencer_opcode_decode.sv
// Combinational opcode decoder: maps the instruction opcode to a one-hot class plus ALU select.
module opcode_decode
  import control_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_t        op_class_o,
  output alu_op_e          alu_op_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    op_class_o = '0;
    alu_op_o   = ALU_ADD;
    case (opcode_i)
      OPC_LD:   op_class_o.ld   = 1'b1;
      OPC_LDI:  op_class_o.ldi  = 1'b1;
      OPC_ST:   op_class_o.st   = 1'b1;
      OPC_ADD:  begin op_class_o.alu = 1'b1; alu_op_o = ALU_ADD; end
      OPC_SUB:  begin op_class_o.alu = 1'b1; alu_op_o = ALU_SUB; end
      OPC_AND:  begin op_class_o.alu = 1'b1; alu_op_o = ALU_AND; end
      OPC_OR:   begin op_class_o.alu = 1'b1; alu_op_o = ALU_OR;  end
      OPC_NOP:  op_class_o.nop  = 1'b1;
      OPC_HALT: op_class_o.halt = 1'b1;
      default:  op_class_o.bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the bus datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unlisted opcodes halt and set a sticky illegal flag.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  output logic                pco,
  output logic                pci,
  output logic                inc_pc,
  output logic                mari,
  output logic                iri,
  output logic                mdri,
  output logic                mdro,
  output logic                read_en,
  output logic                write_en,
  output logic                ryi,
  output logic                rzi,
  output logic                rzo,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                rin,
  output logic                rout,
  output logic                baout,
  output logic                cout,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                illegal
);

  state_e    state_q, state_d;
  op_class_t op_class;
  alu_op_e   dec_alu_op;
  alu_op_e   alu_sel;
  logic      mem_ack;
  logic      imm_class;
  logic      trap;
  logic      unused_sigs;

  // A memory completion coinciding with clear is dropped along with the access.
  assign mem_ack   = mem_ready & ~clear;
  assign imm_class = op_class.ld | op_class.ldi | op_class.st;

  opcode_decode u_decode (
    .opcode_i   (ir[IR_W-1 -: OPC_W]),
    .op_class_o (op_class),
    .alu_op_o   (dec_alu_op)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clock) begin
    if (clear) illegal_q <= 1'b0;
    else if (state_q == S_T3 && op_class.bad) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
  assign trap    = op_class.bad;
`else
  assign illegal = 1'b0;
  assign trap    = 1'b0;
`endif

  assign unused_sigs = ^{ir[IR_W-OPC_W-1:0], op_class.nop, op_class.bad};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ack) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (op_class.alu || imm_class)     state_d = S_T4;
        else if (op_class.halt || trap)    state_d = S_HALT;
        else                               state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (op_class.ld || op_class.st) ? S_T6 : S_T0;
      S_T6:   if (op_class.st || mem_ack) state_d = S_T7;
      S_T7:   if (op_class.ld || mem_ack) state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pco = 1'b0;  pci = 1'b0;  inc_pc = 1'b0;  mari = 1'b0;  iri = 1'b0;
    mdri = 1'b0; mdro = 1'b0; read_en = 1'b0; write_en = 1'b0;
    ryi = 1'b0;  rzi = 1'b0;  rzo = 1'b0;
    gra = 1'b0;  grb = 1'b0;  grc = 1'b0;  rin = 1'b0;  rout = 1'b0;
    baout = 1'b0; cout = 1'b0; halted = 1'b0;
    alu_sel = ALU_ADD;
    case (state_q)
      S_T0: begin pco = 1'b1; mari = 1'b1; inc_pc = 1'b1; end
      S_T1: begin read_en = 1'b1; mdri = mem_ack; end
      S_T2: begin mdro = 1'b1; iri = 1'b1; end
      S_T3: begin
        if (op_class.alu)   begin grb = 1'b1; rout = 1'b1;  ryi = 1'b1; end
        else if (imm_class) begin grb = 1'b1; baout = 1'b1; ryi = 1'b1; end
      end
      S_T4: begin
        if (op_class.alu) begin
          grc = 1'b1; rout = 1'b1; rzi = 1'b1; alu_sel = dec_alu_op;
        end else if (imm_class) begin
          cout = 1'b1; rzi = 1'b1;
        end
      end
      S_T5: begin
        rzo = 1'b1;
        if (op_class.ld || op_class.st) mari = 1'b1;
        else begin gra = 1'b1; rin = 1'b1; end
      end
      S_T6: begin
        if (op_class.ld)      begin read_en = 1'b1; mdri = mem_ack; end
        else if (op_class.st) begin gra = 1'b1; rout = 1'b1; mdri = 1'b1; end
      end
      S_T7: begin
        if (op_class.ld)      begin mdro = 1'b1; gra = 1'b1; rin = 1'b1; end
        else if (op_class.st) write_en = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_sel);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction strobe-step model compared against the DUT every cycle.
module tb_control_sequencer;

  localparam int IR_W     = 32;
  localparam int ALU_OP_W = 4;

  logic                clock = 1'b0;
  logic                clear, run, mem_ready;
  logic [IR_W-1:0]     ir;
  logic                pco, pci, inc_pc, mari, iri, mdri, mdro, read_en, write_en;
  logic                ryi, rzi, rzo, gra, grb, grc, rin, rout, baout, cout;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted, illegal;

  always #5 clock = ~clock;

  control_sequencer #(.IR_W(IR_W), .ALU_OP_W(ALU_OP_W)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pco(pco), .pci(pci), .inc_pc(inc_pc), .mari(mari), .iri(iri),
    .mdri(mdri), .mdro(mdro), .read_en(read_en), .write_en(write_en),
    .ryi(ryi), .rzi(rzi), .rzo(rzo), .gra(gra), .grb(grb), .grc(grc),
    .rin(rin), .rout(rout), .baout(baout), .cout(cout), .alu_op(alu_op),
    .halted(halted), .illegal(illegal)
  );

  typedef struct packed {
    logic pco, pci, inc_pc, mari, iri, mdri, mdro, read_en, write_en;
    logic ryi, rzi, rzo, gra, grb, grc, rin, rout, baout, cout;
    logic [ALU_OP_W-1:0] alu_op;
    logic halted, illegal;
  } out_t;

  typedef struct {
    out_t            o;
    logic            mr, rn, clr, tag;
    logic [IR_W-1:0] irv;
  } step_t;

  step_t  q[$];
  string  qn[$];
  int     checks = 0;
  int     errors = 0;
  out_t   dut_out, cur_exp;
  string  cur_name;
  logic   cur_tag = 1'b0;
  bit     cmp_en  = 1'b0;
  int     re_cnt  = 0;
  int     mdri_cnt = 0;

  logic [IR_W-1:0] m_ir = '0;
  logic            m_run = 1'b0, m_clr = 1'b0, m_tag = 1'b0;

  assign dut_out = {pco, pci, inc_pc, mari, iri, mdri, mdro, read_en, write_en,
                    ryi, rzi, rzo, gra, grb, grc, rin, rout, baout, cout,
                    alu_op, halted, illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input out_t o, input logic mr, input string nm);
    step_t e;
    e.o = o; e.mr = mr; e.rn = m_run; e.clr = m_clr; e.tag = m_tag; e.irv = m_ir;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  // Fetch: PC out, wf read-wait cycles, ready cycle, IR load.
  task automatic fetch(input int wf);
    out_t o;
    o = '0; o.pco = 1; o.mari = 1; o.inc_pc = 1; push(o, 1'b1, "fetch_pc");
    for (int i = 0; i < wf; i++) begin
      o = '0; o.read_en = 1; push(o, 1'b0, "fetch_wait");
    end
    o = '0; o.read_en = 1; o.mdri = 1; push(o, 1'b1, "fetch_ready");
    o = '0; o.mdro = 1; o.iri = 1;     push(o, 1'b1, "fetch_ir");
  endtask

  // Whole instruction from its opcode; wd = data-phase wait cycles for ld/st.
  task automatic instr(input logic [4:0] opc, input int wf, input int wd);
    out_t o;
    int   code;
    code = int'(opc);
    m_ir = {opc, 27'h0A5_5A5A};
    fetch(wf);
    if (code >= 3 && code <= 6) begin
      o = '0; o.grb = 1; o.rout = 1; o.ryi = 1; push(o, 1'b1, "alu_y");
      o = '0; o.grc = 1; o.rout = 1; o.rzi = 1; o.alu_op = ALU_OP_W'(code - 3);
      push(o, 1'b1, "alu_z");
      o = '0; o.rzo = 1; o.gra = 1; o.rin = 1; push(o, 1'b1, "alu_wb");
    end else if (code <= 2) begin
      o = '0; o.grb = 1; o.baout = 1; o.ryi = 1; push(o, 1'b1, "ea_y");
      o = '0; o.cout = 1; o.rzi = 1;             push(o, 1'b1, "ea_z");
      if (code == 1) begin
        o = '0; o.rzo = 1; o.gra = 1; o.rin = 1; push(o, 1'b1, "ldi_wb");
      end else begin
        o = '0; o.rzo = 1; o.mari = 1; push(o, 1'b1, "ea_mar");
        if (code == 0) begin
          for (int i = 0; i < wd; i++) begin
            o = '0; o.read_en = 1; push(o, 1'b0, "ld_wait");
          end
          o = '0; o.read_en = 1; o.mdri = 1; push(o, 1'b1, "ld_ready");
          o = '0; o.mdro = 1; o.gra = 1; o.rin = 1; push(o, 1'b1, "ld_wb");
        end else begin
          o = '0; o.gra = 1; o.rout = 1; o.mdri = 1; push(o, 1'b1, "st_mdr");
          for (int i = 0; i < wd; i++) begin
            o = '0; o.write_en = 1; push(o, 1'b0, "st_wait");
          end
          o = '0; o.write_en = 1; push(o, 1'b1, "st_ready");
        end
      end
    end else begin
      push('0, 1'b1, "decode_only");
    end
  endtask

  task automatic play();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clock);
      ir = e.irv; mem_ready = e.mr; run = e.rn; clear = e.clr;
      cur_exp = e.o; cur_tag = e.tag; cur_name = qn.pop_front();
      cmp_en = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    cmp_en = 1'b0;
  endtask

  always @(negedge clock) begin
    #2;
    if (cmp_en) begin
      check(cur_name, 32'(dut_out), 32'(cur_exp));
      if (cur_tag && read_en) re_cnt++;
      if (cur_tag && mdri)    mdri_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    out_t o;
    int   n;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    @(posedge clock);

    m_clr = 1; push('0, 1'b1, "reset_clear"); m_clr = 0;
    repeat (5) push('0, 1'b1, "idle_hold");
    m_run = 1; push('0, 1'b1, "idle_run"); m_run = 0;

    n = q.size(); instr(5'b00100, 0, 0);
    check("model_sub_len", q.size() - n, 6);
    m_tag = 1; n = q.size(); instr(5'b00011, 3, 0); m_tag = 0;
    check("model_fetch_wait_len", q.size() - n, 9);
    n = q.size(); instr(5'b00000, 0, 2);
    check("model_ld_len", q.size() - n, 10);
    n = q.size(); instr(5'b00010, 1, 2);
    check("model_st_len", q.size() - n, 11);
    instr(5'b00001, 0, 0);
    instr(5'b00101, 2, 0);
    instr(5'b00110, 0, 0);
    n = q.size(); instr(5'b11010, 0, 0);
    check("model_nop_len", q.size() - n, 4);
    instr(5'b11111, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    o = '0; o.halted = 1; o.illegal = 1;
    m_run = 1; repeat (3) push(o, 1'b1, "illegal_halt"); m_run = 0;
    m_clr = 1; push(o, 1'b1, "illegal_clear"); m_clr = 0;
    push('0, 1'b1, "illegal_idle");
    m_run = 1; push('0, 1'b1, "idle_run"); m_run = 0;
`endif

    m_ir = {5'b00100, 27'h0};
    o = '0; o.pco = 1; o.mari = 1; o.inc_pc = 1; push(o, 1'b1, "abort_pc");
    o = '0; o.read_en = 1; push(o, 1'b0, "abort_wait");
    m_clr = 1; push(o, 1'b1, "abort_clear_ready"); m_clr = 0;
    push('0, 1'b0, "abort_idle");
    push('0, 1'b1, "abort_idle");
    m_run = 1; push('0, 1'b1, "idle_run"); m_run = 0;

    instr(5'b11011, 0, 0);
    o = '0; o.halted = 1;
    m_run = 1; repeat (4) push(o, 1'b1, "halt_hold"); m_run = 0;
    m_clr = 1; push(o, 1'b1, "halt_clear"); m_clr = 0;
    push('0, 1'b1, "halt_idle");

    play();

    check("fetch_wait_read_en_cycles", re_cnt, 4);
    check("fetch_wait_mdri_cycles", mdri_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
